// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side controllers of the async FIFO.
// Functions work on a wide container; callers cast to their own pointer width.
package fifo_pkg;

  localparam int PTR_MAX = 16;
  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray pointers of width w are a full distance apart when the top two bits differ and the rest match.
  function automatic logic ptr_full(input ptr_t wg, input ptr_t rg, input int w);
    ptr_t mask;
    ptr_t flip;
    mask = (ptr_t'(1) << w) - ptr_t'(1);
    flip = ptr_t'(3) << (w - 2);
    return ((wg ^ flip) & mask) == (rg & mask);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Latency 2 cycles; no handshake, the source guarantees single-bit changes.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/write_ctrl.sv
// Write-side pointer/flag controller of the async FIFO (clk_w domain).
// write is combinational; flags and level are registered; producer is held off by FIFO_full.
module write_ctrl
  import fifo_pkg::*;
#(
  parameter int width     = 32,
  parameter int depth     = 8,
  parameter int adr_width = $clog2(depth),
  parameter int afull_gap = 2
) (
  input  logic                 clk_w,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [adr_width:0]   rd_ptr_gray,
  output logic                 write,
  output logic [adr_width:0]   write_adr,
  output logic [adr_width:0]   wr_ptr_gray,
  output logic                 FIFO_full,
  output logic                 almost_full,
  output logic [adr_width:0]   wr_level,
  output logic                 wr_ack,
  output logic                 overflow
);

  localparam int PTR_W = adr_width + 1;
  localparam logic [PTR_W-1:0] AFULL_TH = PTR_W'(depth - afull_gap);

  if (width < 1) begin : g_bad_width
    $error("write_ctrl: width must be at least 1");
  end
  if (depth < 4 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("write_ctrl: depth must be a power of two >= 4");
  end
  if (afull_gap < 1 || afull_gap >= depth) begin : g_bad_gap
    $error("write_ctrl: afull_gap out of range");
  end

  logic [PTR_W-1:0] bin;
  logic [PTR_W-1:0] next_bin;
  logic [PTR_W-1:0] next_gray;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] rq2_bin;
  logic [PTR_W-1:0] next_level;
  logic             next_full;

  sync_2ff #(.W(PTR_W)) u_rd_sync (
    .clk   (clk_w),
    .reset (reset),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  assign write      = wr_en && !FIFO_full && !reset;
  assign next_bin   = write ? bin + PTR_W'(1) : bin;
  assign next_gray  = PTR_W'(bin2gray(ptr_t'(next_bin)));
  assign rq2_bin    = PTR_W'(gray2bin(ptr_t'(rq2)));
  // Level is measured against the stale synchronized read pointer, so it can only over-estimate.
  assign next_level = next_bin - rq2_bin;
  assign next_full  = ptr_full(ptr_t'(next_gray), ptr_t'(rq2), PTR_W);

  assign write_adr  = bin;

  always_ff @(posedge clk_w) begin
    if (reset) begin
      bin         <= '0;
      wr_ptr_gray <= '0;
      FIFO_full   <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      bin         <= next_bin;
      wr_ptr_gray <= next_gray;
      FIFO_full   <= next_full;
      almost_full <= next_level >= AFULL_TH;
      wr_level    <= next_level;
      wr_ack      <= write;
      if (wr_en && FIFO_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_ctrl.sv
// Scoreboard bench for write_ctrl (depth 8, afull_gap 2): directed scenarios plus a random phase.
module tb_write_ctrl;

  logic       clk_w = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] rd_ptr_gray;
  logic       write;
  logic [3:0] write_adr;
  logic [3:0] wr_ptr_gray;
  logic       FIFO_full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       wr_ack;
  logic       overflow;

  always #5 clk_w = ~clk_w;

  write_ctrl #(.width(32), .depth(8), .afull_gap(2)) dut (
    .clk_w       (clk_w),
    .reset       (reset),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .write       (write),
    .write_adr   (write_adr),
    .wr_ptr_gray (wr_ptr_gray),
    .FIFO_full   (FIFO_full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .wr_ack      (wr_ack),
    .overflow    (overflow)
  );

  typedef struct {
    logic       write;
    logic [3:0] adr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ack;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;

  // reference model in terms of write/read counts rather than pointers
  int   m_w, m_rq1, m_rq2, m_level, rc;
  logic m_full, m_afull, m_ack, m_ovf;

  function automatic logic [3:0] g_of(input int c);
    logic [3:0] b;
    b = c[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_w = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ack = 0; m_ovf = 0;
  endtask

  task automatic step(input logic we, input logic rst);
    exp_t e;
    int   lvl;
    wr_en       = we;
    reset       = rst;
    rd_ptr_gray = g_of(rc);
    e.write = we && !m_full && !rst;
    e.adr   = 4'(m_w & 15);
    e.gray  = g_of(m_w);
    e.full  = m_full;
    e.afull = m_afull;
    e.level = 4'(m_level);
    e.ack   = m_ack;
    e.ovf   = m_ovf;
    sb.push_back(e);
    @(posedge clk_w);
    if (rst) begin
      model_clear();
    end else begin
      if (we && m_full) m_ovf = 1'b1;
      if (e.write) m_w++;
      lvl     = (m_w - m_rq2) & 15;
      m_level = lvl;
      m_full  = (lvl == 8);
      m_afull = (lvl >= 6);
      m_ack   = e.write;
      m_rq2   = m_rq1;
      m_rq1   = rc;
    end
    #1;
  endtask

  always @(negedge clk_w) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("write",       write,       me.write);
      chk("write_adr",   write_adr,   me.adr);
      chk("wr_ptr_gray", wr_ptr_gray, me.gray);
      chk("FIFO_full",   FIFO_full,   me.full);
      chk("almost_full", almost_full, me.afull);
      chk("wr_level",    wr_level,    me.level);
      chk("wr_ack",      wr_ack,      me.ack);
      chk("overflow",    overflow,    me.ovf);
      chk("level_le_8",  32'(wr_level <= 4'd8), 32'd1);
    end
  end

  initial begin
    wr_en = 0; reset = 1; rc = 0; rd_ptr_gray = 0;
    model_clear();
    repeat (2) @(posedge clk_w);
    #1;

    // 1: fill from empty
    step(0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, 0);
      if (i == 5) chk("t1_afull_5", almost_full, 1'b0);
      if (i == 6) chk("t1_afull_6", almost_full, 1'b1);
    end
    chk("t1_adr",   write_adr,   4'b1000);
    chk("t1_gray",  wr_ptr_gray, 4'b1100);
    chk("t1_full",  FIFO_full,   1'b1);
    chk("t1_level", wr_level,    4'd8);

    // 2: write while full
    step(1, 0);
    chk("t2_adr", write_adr, 4'd8);
    chk("t2_ovf", overflow,  1'b1);
    step(0, 0);
    chk("t2_ovf_sticky", overflow, 1'b1);

    // 3: release after one read, two-edge latency
    rc = 1;
    step(0, 0);
    chk("t3_full_e0", FIFO_full, 1'b1);
    step(0, 0);
    chk("t3_full_e1", FIFO_full, 1'b1);
    step(0, 0);
    chk("t3_full_e2", FIFO_full, 1'b0);
    step(1, 0);
    chk("t3_adr", write_adr, 4'd9);

    // 4: wrap with reader trailing by three
    rc = 0;
    step(0, 1);
    chk("t4_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rc = (m_w > 3) ? m_w - 3 : 0;
      step(1, 0);
      chk("t4_no_full", FIFO_full, 1'b0);
      if (i == 14) begin
        chk("t4_adr15",  write_adr,   4'd15);
        chk("t4_gray15", wr_ptr_gray, 4'b1000);
      end
      if (i == 15) begin
        chk("t4_adr0",  write_adr,   4'd0);
        chk("t4_gray0", wr_ptr_gray, 4'b0000);
      end
    end

    // 5: reset mid-burst
    rc = 0;
    step(0, 1);
    repeat (3) step(1, 0);
    chk("t5_pre_adr", write_adr, 4'd3);
    step(1, 1);
    chk("t5_adr",   write_adr,   4'd0);
    chk("t5_gray",  wr_ptr_gray, 4'd0);
    chk("t5_level", wr_level,    4'd0);
    chk("t5_ack",   wr_ack,      1'b0);
    chk("t5_full",  FIFO_full,   1'b0);
    step(1, 0);
    chk("t5_next_adr", write_adr, 4'd1);

    // 6: random producer against a slow, legal reader
    rc = 0;
    step(0, 1);
    for (int i = 0; i < 400; i++) begin
      if (rc < m_w && $urandom_range(0, 2) == 0) rc++;
      step(1'($urandom_range(0, 1)), 0);
    end

    step(0, 0);
    @(negedge clk_w);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
